// File: rtl/adc_burst_packer.sv
// ---------------------------------------------------------------------------
// adc_burst_packer
//
// Buffers the 128-bit trigger-gated sample stream from the ADC capture stage
// and serialises each sample into two 64-bit AXI4-Stream beats for the DMA
// writer. The capture stream has no backpressure. Every sample is held for
// one cycle in a pending stage, so the end of a burst (tvalid falling) is
// known when the sample is committed. The FIFO keeps its final slot for a
// burst terminator, so any burst that lands in the FIFO is closed by tlast.
//
// Ports
//   aclk, aresetn     clock, asynchronous active-low reset
//   s_axis_tvalid     sample valid from the capture stage (no ready)
//   s_axis_tdata      {sample_counter[63:0], a, b, sum, marker}
//   clear_stats       synchronous clear of the statistics counters
//   m_axis_tvalid     output beat valid
//   m_axis_tready     downstream ready
//   m_axis_tdata      output beat: low half of the sample, then high half
//   m_axis_tlast      high on the second beat of a burst's final sample
//   fifo_level        entries in the FIFO (holding register not included)
//   dropped_count     samples discarded for lack of room, saturating
//   samples_written   samples accepted into the FIFO, wrapping
//   bursts_closed     entries written with the last flag, wrapping
// ---------------------------------------------------------------------------
module adc_burst_packer #(
   parameter int FIFO_DEPTH  = 256,
   parameter int LEVEL_WIDTH = $clog2(FIFO_DEPTH) + 1
) (
   input  logic                   aclk,
   input  logic                   aresetn,
   input  logic                   s_axis_tvalid,
   input  logic [127:0]           s_axis_tdata,
   input  logic                   clear_stats,
   output logic                   m_axis_tvalid,
   input  logic                   m_axis_tready,
   output logic [63:0]            m_axis_tdata,
   output logic                   m_axis_tlast,
   output logic [LEVEL_WIDTH-1:0] fifo_level,
   output logic [31:0]            dropped_count,
   output logic [31:0]            samples_written,
   output logic [15:0]            bursts_closed
);

   localparam int AW = $clog2(FIFO_DEPTH);
   localparam logic [AW:0] DEPTH_V    = FIFO_DEPTH[AW:0];
   localparam logic [AW:0] DEPTH_M1_V = DEPTH_V - 1'b1;

   typedef enum logic [1:0] {IDLE, BEAT0, BEAT1} state_t;

   // pending stage
   logic         pend_v;
   logic [127:0] pend_data;

   // FIFO storage: bit 128 carries the last flag
   logic [128:0] mem [FIFO_DEPTH];
   logic [AW:0]  wr_ptr, rd_ptr;
   logic [AW:0]  level;
   logic [128:0] rd_entry;

   // serialiser
   state_t       state;
   logic [63:0]  hold_hi;
   logic         hold_last;

   logic commit_last, full, last_slot_only, wr_en, drop, empty, pop;

   assign level      = wr_ptr - rd_ptr;
   assign fifo_level = LEVEL_WIDTH'(level);
   assign empty      = (level == '0);
   assign rd_entry   = mem[rd_ptr[AW-1:0]];

   // The held sample is the last of its burst when no sample follows it.
   assign commit_last    = ~s_axis_tvalid;
   // Both tests use the level before any read in this cycle, so a pop does
   // not free room for a commit on the same edge.
   assign full           = (level == DEPTH_V);
   assign last_slot_only = (level == DEPTH_M1_V) && !commit_last;
   assign wr_en          = pend_v && !full && !last_slot_only;
   assign drop           = pend_v && !wr_en;

   // Pop when idle, or when the second beat completes, so consecutive
   // entries stream without a bubble between them.
   assign pop = !empty && ((state == IDLE) || (state == BEAT1 && m_axis_tready));

   // Storage is not reset; pointers define what is valid.
   always_ff @(posedge aclk) begin
      if (wr_en) mem[wr_ptr[AW-1:0]] <= {commit_last, pend_data};
   end

   always_ff @(posedge aclk or negedge aresetn) begin
      if (!aresetn) begin
         pend_v    <= 1'b0;
         pend_data <= '0;
         wr_ptr    <= '0;
         rd_ptr    <= '0;
      end else begin
         pend_v <= s_axis_tvalid;
         if (s_axis_tvalid) pend_data <= s_axis_tdata;
         if (wr_en) wr_ptr <= wr_ptr + 1'b1;
         if (pop)   rd_ptr <= rd_ptr + 1'b1;
      end
   end

   // Statistics; a commit coinciding with clear_stats is not counted.
   always_ff @(posedge aclk or negedge aresetn) begin
      if (!aresetn) begin
         dropped_count   <= '0;
         samples_written <= '0;
         bursts_closed   <= '0;
      end else if (clear_stats) begin
         dropped_count   <= '0;
         samples_written <= '0;
         bursts_closed   <= '0;
      end else begin
         if (drop && dropped_count != 32'hFFFF_FFFF)
            dropped_count <= dropped_count + 32'd1;
         if (wr_en) begin
            samples_written <= samples_written + 32'd1;
            if (commit_last) bursts_closed <= bursts_closed + 16'd1;
         end
      end
   end

   // Output serialiser with registered beat outputs. The low half is driven
   // straight from the popped entry; the high half and flag wait in hold_*.
   always_ff @(posedge aclk or negedge aresetn) begin
      if (!aresetn) begin
         state         <= IDLE;
         m_axis_tvalid <= 1'b0;
         m_axis_tdata  <= '0;
         m_axis_tlast  <= 1'b0;
         hold_hi       <= '0;
         hold_last     <= 1'b0;
      end else if (pop) begin
         state         <= BEAT0;
         m_axis_tvalid <= 1'b1;
         m_axis_tdata  <= rd_entry[63:0];
         m_axis_tlast  <= 1'b0;
         hold_hi       <= rd_entry[127:64];
         hold_last     <= rd_entry[128];
      end else begin
         case (state)
            BEAT0: begin
               if (m_axis_tready) begin
                  state        <= BEAT1;
                  m_axis_tdata <= hold_hi;
                  m_axis_tlast <= hold_last;
               end
            end
            BEAT1: begin
               if (m_axis_tready) begin
                  state         <= IDLE;
                  m_axis_tvalid <= 1'b0;
                  m_axis_tlast  <= 1'b0;
               end
            end
            default: ;
         endcase
      end
   end

endmodule

// File: tb/tb_adc_burst_packer.sv
module tb_adc_burst_packer;

   localparam int D  = 4;
   localparam int LW = $clog2(D) + 1;

   logic          aclk = 1'b0;
   logic          aresetn = 1'b0;
   logic          s_axis_tvalid = 1'b0;
   logic [127:0]  s_axis_tdata = '0;
   logic          clear_stats = 1'b0;
   logic          m_axis_tvalid;
   logic          m_axis_tready = 1'b0;
   logic [63:0]   m_axis_tdata;
   logic          m_axis_tlast;
   logic [LW-1:0] fifo_level;
   logic [31:0]   dropped_count;
   logic [31:0]   samples_written;
   logic [15:0]   bursts_closed;

   adc_burst_packer #(.FIFO_DEPTH(D)) dut (
      .aclk(aclk), .aresetn(aresetn),
      .s_axis_tvalid(s_axis_tvalid), .s_axis_tdata(s_axis_tdata),
      .clear_stats(clear_stats),
      .m_axis_tvalid(m_axis_tvalid), .m_axis_tready(m_axis_tready),
      .m_axis_tdata(m_axis_tdata), .m_axis_tlast(m_axis_tlast),
      .fifo_level(fifo_level), .dropped_count(dropped_count),
      .samples_written(samples_written), .bursts_closed(bursts_closed)
   );

   always #5 aclk = ~aclk;

   int pass_cnt = 0;
   int total_cnt = 0;

   task automatic check(input string name, input logic [127:0] act, input logic [127:0] req);
      total_cnt++;
      if (act === req) pass_cnt++;
      else $display("FAIL %s: actual %0h required %0h (t=%0t)", name, act, req, $time);
   endtask

   // ---------------- reference model ----------------
   // Sample queue, a pending sample, the number of beats still owed for the
   // entry being sent, and the expected beat list ({last, data}).
   logic [128:0] mq[$];
   logic [64:0]  exp_q[$];
   logic         m_pend_v = 1'b0;
   logic [127:0] m_pend_d = '0;
   int           m_rem = 0;
   logic [31:0]  m_drop = '0, m_sw = '0;
   logic [15:0]  m_bc = '0;

   always @(posedge aclk or negedge aresetn) begin
      if (!aresetn) begin
         mq.delete(); exp_q.delete();
         m_pend_v = 1'b0; m_rem = 0;
         m_drop = '0; m_sw = '0; m_bc = '0;
      end else begin
         int lvl;
         bit do_pop, last, accept;
         logic [128:0] ent;
         lvl = mq.size();
         do_pop = (lvl > 0) && (m_rem == 0 || (m_rem == 1 && m_axis_tready));
         if (m_rem > 0 && m_axis_tready) m_rem--;
         if (do_pop) begin
            ent = mq.pop_front();
            m_rem = 2;
            exp_q.push_back({1'b0, ent[63:0]});
            exp_q.push_back({ent[128], ent[127:64]});
         end
         if (m_pend_v) begin
            last   = !s_axis_tvalid;
            accept = (lvl < D) && (last || lvl < D - 1);
            if (accept) mq.push_back({last, m_pend_d});
            if (!clear_stats) begin
               if (accept) begin
                  m_sw++;
                  if (last) m_bc++;
               end else if (m_drop != 32'hFFFF_FFFF) m_drop++;
            end
         end
         if (clear_stats) begin
            m_drop = '0; m_sw = '0; m_bc = '0;
         end
         m_pend_v = s_axis_tvalid;
         if (s_axis_tvalid) m_pend_d = s_axis_tdata;
      end
   end

   // ---------------- monitor / scoreboard ----------------
   always @(negedge aclk) begin
      if (aresetn) begin
         check("tvalid", {127'd0, m_axis_tvalid}, {127'd0, (m_rem > 0)});
         check("fifo_level", {{(128-LW){1'b0}}, fifo_level}, 128'(mq.size()));
         check("dropped_count", {96'd0, dropped_count}, {96'd0, m_drop});
         check("samples_written", {96'd0, samples_written}, {96'd0, m_sw});
         check("bursts_closed", {112'd0, bursts_closed}, {112'd0, m_bc});
         if (m_axis_tvalid) begin
            if (exp_q.size() == 0) begin
               check("unexpected_beat", {63'd0, m_axis_tlast, m_axis_tdata}, 128'd0);
            end else begin
               check("beat", {63'd0, m_axis_tlast, m_axis_tdata}, {63'd0, exp_q[0]});
               if (m_axis_tready) void'(exp_q.pop_front());
            end
         end
      end
   end

   // ---------------- stimulus ----------------
   int rdy_mode = 0; // 0: ready, 1: stalled, 2: toggling, 3: random

   task automatic tick();
      @(posedge aclk);
      #1;
      case (rdy_mode)
         0: m_axis_tready = 1'b1;
         1: m_axis_tready = 1'b0;
         2: m_axis_tready = ~m_axis_tready;
         default: m_axis_tready = 1'($urandom_range(0, 1));
      endcase
   endtask

   task automatic burst(input int n, input logic [63:0] cnt);
      for (int i = 0; i < n; i++) begin
         s_axis_tvalid = 1'b1;
         s_axis_tdata  = {cnt + 64'(i), $urandom(), $urandom()};
         tick();
      end
      s_axis_tvalid = 1'b0;
   endtask

   task automatic idle(input int n);
      s_axis_tvalid = 1'b0;
      repeat (n) tick();
   endtask

   task automatic clr();
      clear_stats = 1'b1;
      tick();
      clear_stats = 1'b0;
   endtask

   initial begin
      repeat (3) @(posedge aclk);
      #1;
      check("rst_tvalid", {127'd0, m_axis_tvalid}, 128'd0);
      check("rst_tlast", {127'd0, m_axis_tlast}, 128'd0);
      check("rst_tdata", {64'd0, m_axis_tdata}, 128'd0);
      check("rst_level", {{(128-LW){1'b0}}, fifo_level}, 128'd0);
      check("rst_counters", {48'd0, dropped_count, samples_written, bursts_closed}, 128'd0);
      aresetn = 1'b1;
      rdy_mode = 0;
      idle(2);

      // single burst of four samples
      burst(4, 64'd100);
      idle(14);
      check("single_sw", {96'd0, samples_written}, 128'd4);
      check("single_bc", {112'd0, bursts_closed}, 128'd1);

      // isolated one-cycle sample
      clr();
      burst(1, 64'd150);
      idle(6);
      check("pulse_bc", {112'd0, bursts_closed}, 128'd1);

      // overflow with downstream stalled, then a burst into the full FIFO
      clr();
      rdy_mode = 1;
      idle(1);
      burst(10, 64'd200);
      idle(4);
      check("ovf_level", {{(128-LW){1'b0}}, fifo_level}, 128'(D));
      burst(3, 64'd300);
      idle(4);
      check("full_level", {{(128-LW){1'b0}}, fifo_level}, 128'(D));
      rdy_mode = 0;
      idle(20);

      // toggling backpressure during a short burst
      clr();
      rdy_mode = 2;
      burst(2, 64'd400);
      idle(16);

      // randomized bursts, ready and statistic clears
      rdy_mode = 3;
      for (int k = 0; k < 40; k++) begin
         burst($urandom_range(1, 7), {32'd0, $urandom()});
         if ($urandom_range(0, 5) == 0) clr();
         idle($urandom_range(0, 6));
      end
      rdy_mode = 0;
      idle(40);
      check("drain_empty", 128'(exp_q.size()), 128'd0);

      // reset while entries are queued
      rdy_mode = 1;
      burst(4, 64'd500);
      idle(3);
      aresetn = 1'b0;
      #1;
      check("rst_mid_tvalid", {127'd0, m_axis_tvalid}, 128'd0);
      check("rst_mid_level", {{(128-LW){1'b0}}, fifo_level}, 128'd0);
      tick(); tick();
      aresetn = 1'b1;
      rdy_mode = 0;
      idle(1);
      check("post_rst_counters", {48'd0, dropped_count, samples_written, bursts_closed}, 128'd0);
      burst(1, 64'd600);
      idle(12);
      check("post_rst_sw", {96'd0, samples_written}, 128'd1);
      check("final_empty", 128'(exp_q.size()), 128'd0);

      $display("%0d/%0d checks passed", pass_cnt, total_cnt);
      $finish;
   end

endmodule
